spi_coef_loader: RTL and testbench
==================================

# spi_coef_loader

Parametrised SPI coefficient loader for the biquad filter bank. It oversamples an external SPI link (`sck`/`sdi`/`cs`) entirely in the `clk_in` domain and deserialises a frame of `NUM_BANDS` × 5 signed coefficients into a shadow register. The frame is validated for exact length, plus an optional CRC-8. A good frame is committed atomically to the active coefficient outputs that feed the filter cascade.

## Interface
Parameters:
- `NUM_BANDS`, 3 — number of biquad bands; 5 coefficients each (`b0,b1,b2,a1,a2`).
- `COEF_W`, 16 — coefficient width, signed two's complement.
- `FRAC_BITS`, 14 — fractional bits; used only for reset value of `b0` (1.0).

Ports:
- `clk_in` input 1 — system clock; single clock domain; must be ≥ 4× `sck` frequency.
- `rst_in` input 1 — asynchronous, active-low reset.
- `sck` input 1 — SPI clock, asynchronous to `clk_in`.
- `sdi` input 1 — SPI data, MSB first, valid on `sck` rising edge.
- `cs` input 1 — frame enable, active-high; a frame is one high period.
- `coef` output `NUM_BANDS*5*COEF_W` — active coefficients, flat; band 0 in LSBs; within a band `b0` lowest, then `b1,b2,a1,a2`.
- `coef_update` output 1 — one-cycle pulse on the cycle `coef` takes new values.
- `frame_err` output 1 — one-cycle pulse when a frame is rejected.
- `busy` output 1 — high from synchronized `cs` rise until return to IDLE.
- `frame_cnt` output 8 — count of accepted frames, wraps 255→0.

## Operation
- `sck`, `sdi`, `cs` each pass through a 2-flop synchronizer. Rising `sck` and rising/falling `cs` are detected from the sync output and one extra delayed stage; `sdi` is delayed to align with the `sck` edge strobe.
- `DATA_BITS = NUM_BANDS*5*COEF_W`; `FRAME_BITS = DATA_BITS` (+8 with CRC). Transmission order is band 0 first, `b0` first within a band, MSB first.
- FSM states:
  - `IDLE`: goes to `SHIFT` on `cs` rise; clears bit counter and CRC.
  - `SHIFT`: each `sck` rise shifts `sdi` into the shadow register and increments the bit counter, which saturates at `FRAME_BITS+1`. On `cs` fall, goes to `CHECK`.
  - `CHECK`: if count==0, goes to `IDLE` silently. If count==`FRAME_BITS` and CRC passes, goes to `COMMIT`. Otherwise pulses `frame_err` and goes to `IDLE`.
  - `COMMIT`: copies shadow to `coef`, pulses `coef_update`, increments `frame_cnt`, goes to `IDLE`.
- The shadow register never drives `coef` directly, so the filters never see a partial update.
- Boundaries:
  - `sck` edge and `cs` fall on the same cycle: the bit is counted first, then the transition to `CHECK` occurs.
  - `cs` rise while not IDLE is impossible by construction, because `CHECK`/`COMMIT` last one cycle each.
- Reset values (all outputs):
  - `coef`: each band `b0 = 1<<FRAC_BITS`, all other coefficients 0 (passthrough).
  - `coef_update`, `frame_err`, `busy`: 0.
  - `frame_cnt`: 0.
  - FSM state: `IDLE`.
- Reset mid-frame aborts the frame; the next full frame after reset is accepted normally.

## Timing
- Input sync plus edge detect: an external edge is seen 3 `clk_in` cycles after it occurs (±1 cycle sampling).
- Cycle N = synchronized `cs` fall observed (`SHIFT`→`CHECK`):
  - N+1: `CHECK` evaluates.
  - N+2: `coef` shows the new values, with `coef_update` = 1 and `frame_cnt` incremented in the same cycle.
  - Rejected frame: `frame_err` = 1 at N+1.
- `busy` falls the cycle after `CHECK` (reject) or after `COMMIT`.
- The minimum `cs` low time between frames is 4 `clk_in` cycles.

## Configuration
- `SPI_COEF_CRC_EN` defined:
  - The frame carries an 8-bit trailer after the data.
  - CRC-8 uses polynomial 0x07, init 0x00, non-reflected, computed serially over the first `DATA_BITS` bits.
  - A mismatch is rejected via `frame_err`.
- Undefined: `FRAME_BITS = DATA_BITS`, no CRC logic is generated, and only the length check applies.

## Structure
- Package `spi_coef_pkg` holds:
  - `COEFS_PER_BAND = 5`.
  - Coefficient index enum (`B0,B1,B2,A1,A2`).
  - FSM state enum.
  - `CRC8_POLY = 8'h07`.
  - Helper function returning the flat bit offset of (band, coef).
- Sub-module `spi_edge_sync` (2-flop sync + delayed stage + rise/fall strobes) is instantiated for `sck` and `cs`; `sdi` uses a matching plain delay chain.

## Test plan
Default parameters: 240 data bits, 248 with CRC.
- Reset → every band's `b0` = 0x4000, all other coefficients 0x0000, `coef_update`=0, `frame_cnt`=0.
- Valid frame with coefficient k = 0x1000+k (k=0..14) → `coef` matches, one `coef_update` pulse, `frame_cnt`=1, no `frame_err`.
- 239-bit frame, then a 241-bit frame → two `frame_err` pulses, `coef` unchanged, `frame_cnt` unchanged.
- `SPI_COEF_CRC_EN` with the trailer's bit 0 flipped → `frame_err`, `coef` unchanged. With the correct trailer → accepted.
- `rst_in` low after 100 bits, then released, then a valid frame → only the second frame is committed, and `frame_cnt`=1.
- `cs` pulsed high with zero `sck` edges → no `frame_err`, no `coef_update`, `busy` pulses for its duration.

Source files
------------

// File: rtl/spi_coef_pkg.sv
// Shared types and constants for the SPI coefficient loader.
// Holds the coefficient index enum, the FSM state enum, the CRC-8 constants and a bit-offset helper.
package spi_coef_pkg;

    localparam int COEFS_PER_BAND = 5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        B0,
        B1,
        B2,
        A1,
        A2
    } coef_idx_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        COMMIT
    } state_e;

    // Flat bit offset of one coefficient: band 0 in the LSBs, b0 lowest within a band.
    function automatic int coef_offset(input int band, input coef_idx_e idx, input int coef_w);
        return (band * COEFS_PER_BAND + int'(idx)) * coef_w;
    endfunction

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer plus one delayed stage, producing a level and rise/fall strobes.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[1:0], din};
        end
    end

    assign level = stages[1];
    assign rise  = stages[1] & ~stages[2];
    assign fall  = ~stages[1] & stages[2];

endmodule

// File: rtl/spi_coef_loader.sv
// Oversampled SPI coefficient loader: shifts a frame into a shadow register and commits it atomically.
// Define SPI_COEF_CRC_EN to require an 8-bit CRC-8 trailer after the coefficient data.
module spi_coef_loader
    import spi_coef_pkg::*;
#(
    parameter int NUM_BANDS = 3,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     sck,
    input  logic                                     sdi,
    input  logic                                     cs,
    output logic [NUM_BANDS*COEFS_PER_BAND*COEF_W-1:0] coef,
    output logic                                     coef_update,
    output logic                                     frame_err,
    output logic                                     busy,
    output logic [7:0]                               frame_cnt
);

    localparam int NUM_COEFS = NUM_BANDS * COEFS_PER_BAND;
    localparam int DATA_BITS = NUM_COEFS * COEF_W;
`ifdef SPI_COEF_CRC_EN
    localparam int FRAME_BITS = DATA_BITS + 8;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

    function automatic logic [DATA_BITS-1:0] reset_coefs();
        logic [DATA_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            r[coef_offset(b, B0, COEF_W) +: COEF_W] = COEF_W'(1) << FRAC_BITS;
        end
        return r;
    endfunction

    // The first coefficient received ends up in the shadow MSBs; reorder into the output layout.
    function automatic logic [DATA_BITS-1:0] unpack(input logic [DATA_BITS-1:0] s);
        logic [DATA_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            for (int c = 0; c < COEFS_PER_BAND; c++) begin
                r[coef_offset(b, coef_idx_e'(c), COEF_W) +: COEF_W] =
                    s[(NUM_COEFS - 1 - (b * COEFS_PER_BAND + c)) * COEF_W +: COEF_W];
            end
        end
        return r;
    endfunction

    localparam logic [DATA_BITS-1:0] RESET_COEF = reset_coefs();

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [1:0] sdi_sync;
    logic sdi_bit;
    logic unused_strobes;

    spi_edge_sync u_sck_sync (
        .clk   (clk_in),
        .rst_n (rst_in),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_edge_sync u_cs_sync (
        .clk   (clk_in),
        .rst_n (rst_in),
        .din   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_strobes = sck_level ^ sck_fall ^ cs_level;

    // Same depth as the strobe source so the sampled bit matches the sck rise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sdi_sync <= '0;
        end else begin
            sdi_sync <= {sdi_sync[0], sdi};
        end
    end

    assign sdi_bit = sdi_sync[1];

    state_e               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shadow;
    logic                 crc_ok;

`ifdef SPI_COEF_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_rx;
    assign crc_ok = (crc == crc_rx);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shadow      <= '0;
            coef        <= RESET_COEF;
            coef_update <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 8'd0;
`ifdef SPI_COEF_CRC_EN
            crc         <= 8'h00;
            crc_rx      <= 8'h00;
`endif
        end else begin
            coef_update <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_rise) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
`ifdef SPI_COEF_CRC_EN
                        crc     <= 8'h00;
                        crc_rx  <= 8'h00;
`endif
                    end
                end
                SHIFT: begin
                    // A bit arriving with the cs fall is still counted before CHECK.
                    if (sck_rise) begin
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
`ifdef SPI_COEF_CRC_EN
                        if (bit_cnt < CNT_W'(DATA_BITS)) begin
                            shadow <= {shadow[DATA_BITS-2:0], sdi_bit};
                            crc    <= crc8_next(crc, sdi_bit);
                        end else begin
                            crc_rx <= {crc_rx[6:0], sdi_bit};
                        end
`else
                        shadow <= {shadow[DATA_BITS-2:0], sdi_bit};
`endif
                    end
                    if (cs_fall) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_cnt == CNT_FRAME && crc_ok) begin
                        state <= COMMIT;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                COMMIT: begin
                    coef        <= unpack(shadow);
                    coef_update <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_coef_loader.sv
// Self-checking bench for spi_coef_loader: random and directed SPI frames against a coefficient-array model.
// Define SPI_COEF_CRC_EN to exercise the CRC trailer build.
module tb_spi_coef_loader;

    localparam int NB = 3;
    localparam int W  = 16;
    localparam int NC = NB * 5;
    localparam int DB = NC * W;
`ifdef SPI_COEF_CRC_EN
    localparam int FB = DB + 8;
`else
    localparam int FB = DB;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic sck    = 1'b0;
    logic sdi    = 1'b0;
    logic cs     = 1'b0;
    logic [DB-1:0] coef;
    logic coef_update;
    logic frame_err;
    logic busy;
    logic [7:0] frame_cnt;

    spi_coef_loader #(
        .NUM_BANDS (NB),
        .COEF_W    (W),
        .FRAC_BITS (14)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sck         (sck),
        .sdi         (sdi),
        .cs          (cs),
        .coef        (coef),
        .coef_update (coef_update),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    int err_seen = 0;
    int busy_cycles = 0;
    int stray = 0;
    logic [DB-1:0] prev_coef;

    // Observe pulses and catch any coef change not flagged by coef_update.
    always @(negedge clk_in) begin
        if (coef_update === 1'b1) upd_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (busy === 1'b1) busy_cycles++;
        if (rst_in && coef !== prev_coef && coef_update !== 1'b1) stray++;
        prev_coef = coef;
    end

    logic [W-1:0] exp_val [NC];
    logic [W-1:0] new_val [NC];
    logic [7:0]   exp_cnt;
    bit           frame_bits [$];

    function automatic logic [DB-1:0] exp_flat();
        logic [DB-1:0] r;
        for (int k = 0; k < NC; k++) r[k*W +: W] = exp_val[k];
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) exp_val[k] = (k % 5 == 0) ? 16'h4000 : 16'h0000;
        exp_cnt = 8'd0;
    endfunction

    function automatic void model_accept();
        for (int k = 0; k < NC; k++) exp_val[k] = new_val[k];
        exp_cnt = exp_cnt + 8'd1;
    endfunction

    function automatic void build_frame();
        logic [7:0] c;
        logic fb;
        frame_bits.delete();
        for (int k = 0; k < NC; k++)
            for (int b = W - 1; b >= 0; b--) frame_bits.push_back(new_val[k][b]);
        c = 8'h00;
        for (int i = 0; i < DB; i++) begin
            fb = c[7] ^ frame_bits[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
`ifdef SPI_COEF_CRC_EN
        for (int b = 7; b >= 0; b--) frame_bits.push_back(c[b]);
`endif
    endfunction

    function automatic void randomize_vals();
        for (int k = 0; k < NC; k++) new_val[k] = W'($urandom);
    endfunction

    task automatic sendBits(input int n);
        @(negedge clk_in);
        cs = 1'b1;
        repeat (6) @(negedge clk_in);
        for (int i = 0; i < n; i++) begin
            sdi = (i < frame_bits.size()) ? frame_bits[i] : 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk_in);
            sck = 1'b1;
            repeat (4) @(negedge clk_in);
            sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int n);
        upd_seen = 0;
        err_seen = 0;
        busy_cycles = 0;
        sendBits(n);
        repeat (4) @(negedge clk_in);
        cs = 1'b0;
        repeat (20) @(negedge clk_in);
    endtask

    task automatic checkOutput(input string tag, input int exp_upd, input int exp_err);
        checks++;
        assert (coef === exp_flat()) else begin
            errors++;
            $error("[TB] FAIL %s coef got %h expected %h", tag, coef, exp_flat());
        end
        checks++;
        assert (frame_cnt === exp_cnt) else begin
            errors++;
            $error("[TB] FAIL %s frame_cnt got %0d expected %0d", tag, frame_cnt, exp_cnt);
        end
        checks++;
        assert (upd_seen === exp_upd) else begin
            errors++;
            $error("[TB] FAIL %s coef_update pulses got %0d expected %0d", tag, upd_seen, exp_upd);
        end
        checks++;
        assert (err_seen === exp_err) else begin
            errors++;
            $error("[TB] FAIL %s frame_err pulses got %0d expected %0d", tag, err_seen, exp_err);
        end
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s busy got %b expected 0", tag, busy);
        end
        checks++;
        assert (stray === 0) else begin
            errors++;
            $error("[TB] FAIL %s unflagged coef changes got %0d expected 0", tag, stray);
        end
    endtask

    initial begin
        model_reset();
        repeat (5) @(negedge clk_in);
        checkOutput("reset", 0, 0);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);

        for (int k = 0; k < NC; k++) new_val[k] = 16'h1000 + W'(k);
        build_frame();
        applyStimulus(FB);
        model_accept();
        checkOutput("fixed_frame", 1, 0);

        for (int r = 0; r < 3; r++) begin
            randomize_vals();
            build_frame();
            applyStimulus(FB);
            model_accept();
            checkOutput("random_frame", 1, 0);
        end

        randomize_vals();
        build_frame();
        applyStimulus(FB - 1);
        checkOutput("short_frame", 0, 1);
        applyStimulus(FB + 1);
        checkOutput("long_frame", 0, 1);

`ifdef SPI_COEF_CRC_EN
        randomize_vals();
        build_frame();
        frame_bits[FB-1] = ~frame_bits[FB-1];
        applyStimulus(FB);
        checkOutput("bad_crc", 0, 1);
        frame_bits[FB-1] = ~frame_bits[FB-1];
        applyStimulus(FB);
        model_accept();
        checkOutput("good_crc", 1, 0);
`endif

        applyStimulus(0);
        checkOutput("empty_cs", 0, 0);
        checks++;
        assert (busy_cycles > 0) else begin
            errors++;
            $error("[TB] FAIL empty_cs busy cycles got %0d expected >0", busy_cycles);
        end

        randomize_vals();
        build_frame();
        upd_seen = 0;
        err_seen = 0;
        sendBits(100);
        rst_in = 1'b0;
        cs = 1'b0;
        sck = 1'b0;
        model_reset();
        repeat (5) @(negedge clk_in);
        checkOutput("mid_reset", 0, 0);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_in);
        randomize_vals();
        build_frame();
        applyStimulus(FB);
        model_accept();
        checkOutput("after_reset", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
